// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: the controller drives
// enable/load/data/direction/mode and observes the count and flags.
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             enable_i;
  logic             load_i;
  logic [WIDTH-1:0] data_i;
  logic             up_i;
  logic             sat_i;
  logic [WIDTH-1:0] count_o;
  logic             wrap_o;
  logic             sat_o;
  logic             at_max_o;
  logic             at_zero_o;

  modport master (
    output enable_i, load_i, data_i, up_i, sat_i,
    input  count_o, wrap_o, sat_o, at_max_o, at_zero_o
  );

  modport slave (
    input  enable_i, load_i, data_i, up_i, sat_i,
    output count_o, wrap_o, sat_o, at_max_o, at_zero_o
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo up/down counter with programmable terminal value, wrap or saturate
// behaviour at the boundaries, an enable prescaler and boundary flags.
module mod_counter #(
  parameter int          WIDTH    = 8,
  parameter logic [31:0] MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int          PRESCALE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];
  localparam int               PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;
  logic             sat_reg, sat_next;
  logic             ps_done;
  logic             step;

  // ps_done marks the enabled cycle that completes a prescale period.
  generate
    if (PRESCALE > 1) begin : g_ps
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] ps_reg, ps_next;

      always_comb begin
        ps_next = ps_reg;
        if (bus.load_i) begin
          ps_next = '0;
        end else if (bus.enable_i) begin
          ps_next = (ps_reg == PS_LAST) ? '0 : ps_reg + 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ps_reg <= '0;
        end else begin
          ps_reg <= ps_next;
        end
      end

      assign ps_done = (ps_reg == PS_LAST);
    end else begin : g_no_ps
      assign ps_done = 1'b1;
    end
  endgenerate

  assign step = bus.enable_i && ps_done && !bus.load_i;

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    sat_next   = sat_reg;
    if (bus.load_i) begin
      count_next = (bus.data_i > MAX_V) ? MAX_V : bus.data_i;
      sat_next   = 1'b0;
    end else if (step) begin
      if (bus.up_i) begin
        if (count_reg != MAX_V) begin
          count_next = count_reg + 1'b1;
          sat_next   = 1'b0;
        end else if (bus.sat_i) begin
          sat_next   = 1'b1;
        end else begin
          count_next = '0;
          wrap_next  = 1'b1;
          sat_next   = 1'b0;
        end
      end else begin
        if (count_reg != '0) begin
          count_next = count_reg - 1'b1;
          sat_next   = 1'b0;
        end else if (bus.sat_i) begin
          sat_next   = 1'b1;
        end else begin
          count_next = MAX_V;
          wrap_next  = 1'b1;
          sat_next   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      sat_reg   <= sat_next;
    end
  end

  assign bus.count_o   = count_reg;
  assign bus.wrap_o    = wrap_reg;
  assign bus.sat_o     = sat_reg;
  assign bus.at_max_o  = (count_reg == MAX_V);
  assign bus.at_zero_o = (count_reg == '0);
endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: one instance without prescaler, one with
// PRESCALE=3, both WIDTH=4 and MAX_VAL=9.
module tb_mod_counter;
  logic clk_i = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  mod_counter_if #(.WIDTH(4)) bus_a ();
  mod_counter_if #(.WIDTH(4)) bus_b ();

  mod_counter #(.WIDTH(4), .MAX_VAL(32'd9), .PRESCALE(1)) dut_a (
    .clk_i (clk_i),
    .rst_i (rst_a),
    .bus   (bus_a.slave)
  );

  mod_counter #(.WIDTH(4), .MAX_VAL(32'd9), .PRESCALE(3)) dut_b (
    .clk_i (clk_i),
    .rst_i (rst_b),
    .bus   (bus_b.slave)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int cnt, input bit wrap, input bit sat);
    check({tag, ".count"}, {28'd0, bus_a.count_o}, cnt);
    check({tag, ".wrap"}, {31'd0, bus_a.wrap_o}, {31'd0, wrap});
    check({tag, ".sat"}, {31'd0, bus_a.sat_o}, {31'd0, sat});
    check({tag, ".at_max"}, {31'd0, bus_a.at_max_o}, (cnt == 9) ? 32'd1 : 32'd0);
    check({tag, ".at_zero"}, {31'd0, bus_a.at_zero_o}, (cnt == 0) ? 32'd1 : 32'd0);
    $display("A %s: count=%0d wrap=%0b sat=%0b", tag, bus_a.count_o, bus_a.wrap_o, bus_a.sat_o);
  endtask

  task automatic chk_b(input string tag, input int cnt);
    check({tag, ".count"}, {28'd0, bus_b.count_o}, cnt);
    check({tag, ".wrap"}, {31'd0, bus_b.wrap_o}, 32'd0);
    $display("B %s: count=%0d", tag, bus_b.count_o);
  endtask

  initial begin
    bus_a.enable_i = 1'b1; bus_a.load_i = 1'b0; bus_a.data_i = 4'd0;
    bus_a.up_i = 1'b1;     bus_a.sat_i = 1'b0;
    bus_b.enable_i = 1'b0; bus_b.load_i = 1'b0; bus_b.data_i = 4'd0;
    bus_b.up_i = 1'b1;     bus_b.sat_i = 1'b0;

    // Reset held two cycles with enable high
    tick(); chk_a("rst0", 0, 1'b0, 1'b0);
    tick(); chk_a("rst1", 0, 1'b0, 1'b0);
    rst_a = 1'b0;

    // Wrap up: 1..9, then 0 with a pulse, then 1
    for (int i = 1; i <= 9; i++) begin
      tick(); chk_a($sformatf("up%0d", i), i, 1'b0, 1'b0);
    end
    tick(); chk_a("wrap_up", 0, 1'b1, 1'b0);
    tick(); chk_a("after_wrap", 1, 1'b0, 1'b0);

    // Wrap down from 0
    bus_a.load_i = 1'b1; bus_a.data_i = 4'd0;
    tick(); chk_a("load0", 0, 1'b0, 1'b0);
    bus_a.load_i = 1'b0; bus_a.up_i = 1'b0;
    tick(); chk_a("wrap_dn", 9, 1'b1, 1'b0);
    tick(); chk_a("dn8", 8, 1'b0, 1'b0);

    // Saturate at top
    bus_a.sat_i = 1'b1; bus_a.up_i = 1'b1;
    bus_a.load_i = 1'b1; bus_a.data_i = 4'd8;
    tick(); chk_a("load8", 8, 1'b0, 1'b0);
    bus_a.load_i = 1'b0;
    tick(); chk_a("sat_s1", 9, 1'b0, 1'b0);
    tick(); chk_a("sat_s2", 9, 1'b0, 1'b1);
    tick(); chk_a("sat_s3", 9, 1'b0, 1'b1);
    bus_a.up_i = 1'b0;
    tick(); chk_a("sat_rev", 8, 1'b0, 1'b0);

    // Saturate at bottom, flag holds while idle
    bus_a.load_i = 1'b1; bus_a.data_i = 4'd0;
    tick(); chk_a("load0b", 0, 1'b0, 1'b0);
    bus_a.load_i = 1'b0;
    tick(); chk_a("sat_bot", 0, 1'b0, 1'b1);
    bus_a.enable_i = 1'b0;
    tick(); chk_a("sat_hold", 0, 1'b0, 1'b1);

    // Load clamp wins over enable; reset wins over load
    bus_a.enable_i = 1'b1; bus_a.up_i = 1'b1; bus_a.sat_i = 1'b0;
    bus_a.load_i = 1'b1; bus_a.data_i = 4'd15;
    tick(); chk_a("clamp", 9, 1'b0, 1'b0);
    bus_a.load_i = 1'b0; bus_a.enable_i = 1'b0;
    tick(); chk_a("clamp_hold", 9, 1'b0, 1'b0);
    rst_a = 1'b1; bus_a.load_i = 1'b1; bus_a.data_i = 4'd5;
    tick(); chk_a("rst_load", 0, 1'b0, 1'b0);
    rst_a = 1'b0; bus_a.load_i = 1'b0;

    // Prescaler: enable pattern 1,1,0,1,1,1,1
    tick();
    rst_b = 1'b0;
    bus_b.enable_i = 1'b1; tick(); chk_b("ps_e1", 0);
    tick(); chk_b("ps_e2", 0);
    bus_b.enable_i = 1'b0; tick(); chk_b("ps_idle", 0);
    bus_b.enable_i = 1'b1; tick(); chk_b("ps_e3", 1);
    tick(); chk_b("ps_e4", 1);
    tick(); chk_b("ps_e5", 1);
    tick(); chk_b("ps_e6", 2);

    // Load after two enabled cycles restarts the period
    tick(); chk_b("pl_e1", 2);
    tick(); chk_b("pl_e2", 2);
    bus_b.load_i = 1'b1; bus_b.data_i = 4'd4;
    tick(); chk_b("pl_load", 4);
    bus_b.load_i = 1'b0;
    tick(); chk_b("pl_a1", 4);
    tick(); chk_b("pl_a2", 4);
    tick(); chk_b("pl_a3", 5);

    // Reset with count 5, prescaler 2
    tick(); chk_b("pr_e1", 5);
    tick(); chk_b("pr_e2", 5);
    rst_b = 1'b1;
    tick(); chk_b("pr_rst", 0);
    rst_b = 1'b0;
    tick(); chk_b("pr_a1", 0);
    tick(); chk_b("pr_a2", 0);
    tick(); chk_b("pr_a3", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
